// File: rtl/key_calc_core.sv
// key_calc_core
// Integer calculator engine fed by the keypad scanner. Collects up to two
// 3-digit decimal operands and one operator, computes +, - or *, and converts
// the binary result to 6 BCD digits with a sequential double-dabble.
//
// Ports:
//   sys_clk    in   1   system clock
//   sys_rst    in   1   asynchronous reset, active-high
//   key_value  in   4   key code (0-9 digits, A-F function keys)
//   value_en   in   1   one-cycle strobe qualifying key_value
//   disp_bcd   out  24  6 BCD digits, [23:20] most significant
//   disp_neg   out  1   displayed value is negative
//   disp_upd   out  1   one-cycle pulse when disp_bcd/disp_neg change
//   calc_done  out  1   one-cycle pulse when a result has been converted
//   busy       out  1   high while computing or converting
module key_calc_core #(
  parameter int          OPD_DIGITS = 3,
  parameter int          RES_W      = 20,
  parameter logic [3:0]  KEY_ADD    = 4'hA,
  parameter logic [3:0]  KEY_SUB    = 4'hB,
  parameter logic [3:0]  KEY_MUL    = 4'hC,
  parameter logic [3:0]  KEY_EQU    = 4'hD,
  parameter logic [3:0]  KEY_CLR    = 4'hE,
  parameter logic [3:0]  KEY_BSP    = 4'hF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  key_value,
  input  logic        value_en,
  output logic [23:0] disp_bcd,
  output logic        disp_neg,
  output logic        disp_upd,
  output logic        calc_done,
  output logic        busy
);

  localparam int OPD_W = 4 * OPD_DIGITS;
  localparam int BCD_W = 24;
  localparam logic [4:0] CONV_LAST = 5'(RES_W - 1);

  typedef enum logic [2:0] {S_A, S_OP, S_B, S_CALC, S_CONV, S_SHOW} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;

  // Binary value of a 3-digit BCD operand.
  function automatic logic [9:0] bcd3_to_bin(input logic [OPD_W-1:0] b);
    return 10'(b[11:8]) * 10'd100 + 10'(b[7:4]) * 10'd10 + 10'(b[3:0]);
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] dd_add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Significant digit count of a 3-digit BCD value (leading zeros dropped).
  function automatic logic [1:0] digit_cnt(input logic [OPD_W-1:0] b);
    if (b[11:8] != 4'd0)      return 2'd3;
    else if (b[7:4] != 4'd0)  return 2'd2;
    else if (b[3:0] != 4'd0)  return 2'd1;
    else                      return 2'd0;
  endfunction

  function automatic op_t key_to_op(input logic [3:0] k);
    if (k == KEY_ADD)      return OP_ADD;
    else if (k == KEY_SUB) return OP_SUB;
    else                   return OP_MUL;
  endfunction

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic              key_vld_q;
  logic [3:0]        key_q;
  logic [OPD_W-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]        a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              neg_q, neg_d;
  logic [RES_W-1:0]  sh_q, sh_d;
  logic [BCD_W-1:0]  work_q, work_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [BCD_W-1:0]  disp_bcd_q, disp_bcd_d;
  logic              disp_neg_q, disp_neg_d;
  logic              disp_upd_q, disp_upd_d;
  logic              calc_done_q, calc_done_d;

  logic              is_digit, is_op, force_upd;
  logic [9:0]        a_bin, b_bin;
  logic [BCD_W+RES_W-1:0] dd_cat;

  assign is_digit = (key_q <= 4'd9);
  assign is_op    = (key_q == KEY_ADD) || (key_q == KEY_SUB) || (key_q == KEY_MUL);
  assign a_bin    = bcd3_to_bin(a_q);
  assign b_bin    = bcd3_to_bin(b_q);

  // Key input register stage: the FSM acts one edge after the sampling edge,
  // which together with S_CALC and 20 conversion steps gives the 22-edge
  // key-to-result latency.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_vld_q <= 1'b0;
      key_q     <= 4'd0;
    end else begin
      key_vld_q <= value_en;
      key_q     <= key_value;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    a_cnt_d     = a_cnt_q;
    b_d         = b_q;
    b_cnt_d     = b_cnt_q;
    res_d       = res_q;
    neg_d       = neg_q;
    sh_d        = sh_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    disp_bcd_d  = disp_bcd_q;
    disp_neg_d  = disp_neg_q;
    calc_done_d = 1'b0;
    force_upd   = 1'b0;
    dd_cat      = {dd_add3(work_q), sh_q} << 1;

    if (key_vld_q && key_q == KEY_CLR) begin
      // Clear wins in every state, including an in-flight calculation.
      state_d    = S_A;
      op_d       = OP_NONE;
      a_d        = '0;
      a_cnt_d    = 2'd0;
      b_d        = '0;
      b_cnt_d    = 2'd0;
      res_d      = '0;
      neg_d      = 1'b0;
      sh_d       = '0;
      work_d     = '0;
      cnt_d      = 5'd0;
      disp_bcd_d = '0;
      disp_neg_d = 1'b0;
      force_upd  = 1'b1;
    end else begin
      case (state_q)
        S_A: if (key_vld_q) begin
          if (is_digit) begin
            if (a_cnt_q < 2'd3) begin
              a_d     = {a_q[7:0], key_q};
              a_cnt_d = a_cnt_q + 2'd1;
            end
          end else if (key_q == KEY_BSP) begin
            a_d     = {4'd0, a_q[11:4]};
            a_cnt_d = (a_cnt_q != 2'd0) ? a_cnt_q - 2'd1 : 2'd0;
          end else if (is_op) begin
            op_d    = key_to_op(key_q);
            state_d = S_OP;
          end else if (key_q == KEY_EQU) begin
            op_d    = OP_NONE;
            state_d = S_CALC;
          end
        end
        S_OP: if (key_vld_q) begin
          if (is_op) begin
            op_d = key_to_op(key_q);
          end else if (is_digit) begin
            b_d     = {8'd0, key_q};
            b_cnt_d = 2'd1;
            state_d = S_B;
          end
        end
        S_B: if (key_vld_q) begin
          if (is_digit) begin
            if (b_cnt_q < 2'd3) begin
              b_d     = {b_q[7:0], key_q};
              b_cnt_d = b_cnt_q + 2'd1;
            end
          end else if (key_q == KEY_BSP) begin
            b_d     = {4'd0, b_q[11:4]};
            b_cnt_d = (b_cnt_q != 2'd0) ? b_cnt_q - 2'd1 : 2'd0;
          end else if (key_q == KEY_EQU) begin
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          neg_d = 1'b0;
          case (op_q)
            OP_ADD: res_d = RES_W'(a_bin) + RES_W'(b_bin);
            OP_SUB: begin
              if (a_bin >= b_bin) begin
                res_d = RES_W'(a_bin - b_bin);
              end else begin
                res_d = RES_W'(b_bin - a_bin);
                neg_d = 1'b1;
              end
            end
            OP_MUL: res_d = RES_W'(a_bin) * RES_W'(b_bin);
            default: res_d = RES_W'(a_bin);
          endcase
          sh_d    = res_d;
          work_d  = '0;
          cnt_d   = 5'd0;
          state_d = S_CONV;
        end
        S_CONV: begin
          work_d = dd_cat[BCD_W+RES_W-1:RES_W];
          sh_d   = dd_cat[RES_W-1:0];
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == CONV_LAST) begin
            disp_bcd_d  = dd_cat[BCD_W+RES_W-1:RES_W];
            disp_neg_d  = neg_q;
            calc_done_d = 1'b1;
            force_upd   = 1'b1;
            state_d     = S_SHOW;
          end
        end
        S_SHOW: if (key_vld_q) begin
          if (is_digit) begin
            a_d     = {8'd0, key_q};
            a_cnt_d = 2'd1;
            b_d     = '0;
            b_cnt_d = 2'd0;
            op_d    = OP_NONE;
            state_d = S_A;
          end else if (is_op && !neg_q && res_q <= RES_W'(999)) begin
            // Chain: the displayed result becomes operand A.
            a_d     = disp_bcd_q[OPD_W-1:0];
            a_cnt_d = digit_cnt(disp_bcd_q[OPD_W-1:0]);
            b_d     = '0;
            b_cnt_d = 2'd0;
            op_d    = key_to_op(key_q);
            state_d = S_OP;
          end
        end
        default: state_d = S_A;
      endcase

      // During entry the display mirrors the operand being edited.
      if (state_d == S_A || state_d == S_OP) begin
        disp_bcd_d = {12'd0, a_d};
        disp_neg_d = 1'b0;
      end else if (state_d == S_B) begin
        disp_bcd_d = {12'd0, b_d};
        disp_neg_d = 1'b0;
      end
    end

    disp_upd_d = force_upd || (disp_bcd_d != disp_bcd_q) || (disp_neg_d != disp_neg_q);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_A;
      op_q        <= OP_NONE;
      a_q         <= '0;
      a_cnt_q     <= 2'd0;
      b_q         <= '0;
      b_cnt_q     <= 2'd0;
      res_q       <= '0;
      neg_q       <= 1'b0;
      sh_q        <= '0;
      work_q      <= '0;
      cnt_q       <= 5'd0;
      disp_bcd_q  <= '0;
      disp_neg_q  <= 1'b0;
      disp_upd_q  <= 1'b0;
      calc_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      a_cnt_q     <= a_cnt_d;
      b_q         <= b_d;
      b_cnt_q     <= b_cnt_d;
      res_q       <= res_d;
      neg_q       <= neg_d;
      sh_q        <= sh_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_neg_q  <= disp_neg_d;
      disp_upd_q  <= disp_upd_d;
      calc_done_q <= calc_done_d;
    end
  end

  assign disp_bcd  = disp_bcd_q;
  assign disp_neg  = disp_neg_q;
  assign disp_upd  = disp_upd_q;
  assign calc_done = calc_done_q;
  assign busy      = (state_q == S_CALC) || (state_q == S_CONV);

endmodule

// File: tb/tb_key_calc_core.sv
module tb_key_calc_core;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  key_value;
  logic        value_en;
  logic [23:0] disp_bcd;
  logic        disp_neg;
  logic        disp_upd;
  logic        calc_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  key_calc_core dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_value (key_value),
    .value_en  (value_en),
    .disp_bcd  (disp_bcd),
    .disp_neg  (disp_neg),
    .disp_upd  (disp_upd),
    .calc_done (calc_done),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One key strobe; returns once the core has acted on it.
  task automatic press(input logic [3:0] k);
    @(negedge sys_clk);
    key_value = k;
    value_en  = 1'b1;
    @(negedge sys_clk);
    value_en  = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic press_str(input string s);
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= 8'h41) press(4'(c - 8'h37));
      else            press(4'(c - 8'h30));
    end
  endtask

  // Called right after KEY_EQU was pressed (one edge past the sampling edge).
  // Counts edges from the sampling edge to calc_done, checks busy throughout.
  task automatic wait_done(input string tag);
    int cyc;
    bit busy_bad;
    cyc = 1;
    busy_bad = 1'b0;
    while (!calc_done && cyc < 40) begin
      if (!busy) busy_bad = 1'b1;
      @(negedge sys_clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd22);
    chk({tag, "_busy_during"}, {31'd0, busy_bad}, 32'd0);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_upd_at_done"}, {31'd0, disp_upd}, 32'd1);
  endtask

  initial begin
    bit saw_done;
    sys_rst   = 1'b1;
    value_en  = 1'b0;
    key_value = 4'd0;
    repeat (3) @(negedge sys_clk);
    chk("rst_bcd", {8'd0, disp_bcd}, 32'h0);
    chk("rst_neg", {31'd0, disp_neg}, 32'd0);
    chk("rst_upd", {31'd0, disp_upd}, 32'd0);
    chk("rst_done", {31'd0, calc_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    sys_rst = 1'b0;

    // 123 + 45 = 168
    press_str("123");
    chk("entry_123", {8'd0, disp_bcd}, 32'h000123);
    chk("entry_upd", {31'd0, disp_upd}, 32'd1);
    press_str("A45");
    chk("entry_45", {8'd0, disp_bcd}, 32'h000045);
    press_str("D");
    chk("busy_calc", {31'd0, busy}, 32'd1);
    wait_done("add");
    chk("add_bcd", {8'd0, disp_bcd}, 32'h000168);
    chk("add_neg", {31'd0, disp_neg}, 32'd0);
    @(negedge sys_clk);
    chk("done_pulse", {31'd0, calc_done}, 32'd0);
    chk("upd_pulse", {31'd0, disp_upd}, 32'd0);

    // Chain: 168 + 2 = 170
    press_str("A");
    chk("chain_op_bcd", {8'd0, disp_bcd}, 32'h000168);
    chk("chain_op_upd", {31'd0, disp_upd}, 32'd0);
    press_str("2");
    chk("chain_b", {8'd0, disp_bcd}, 32'h000002);
    press_str("D");
    wait_done("chain");
    chk("chain_bcd", {8'd0, disp_bcd}, 32'h000170);

    // 12 - 300 = -288
    press_str("E");
    chk("clr_bcd", {8'd0, disp_bcd}, 32'h0);
    chk("clr_upd", {31'd0, disp_upd}, 32'd1);
    press_str("12B300");
    chk("sub_b", {8'd0, disp_bcd}, 32'h000300);
    press_str("D");
    wait_done("subneg");
    chk("subneg_bcd", {8'd0, disp_bcd}, 32'h000288);
    chk("subneg_neg", {31'd0, disp_neg}, 32'd1);

    // 999 * 999 = 998001, then chaining is refused
    press_str("E999C999D");
    wait_done("mul");
    chk("mul_bcd", {8'd0, disp_bcd}, 32'h998001);
    chk("mul_neg", {31'd0, disp_neg}, 32'd0);
    press_str("A");
    chk("big_op_bcd", {8'd0, disp_bcd}, 32'h998001);
    chk("big_op_upd", {31'd0, disp_upd}, 32'd0);
    press_str("0");
    chk("new_a0", {8'd0, disp_bcd}, 32'h000000);
    chk("new_a0_upd", {31'd0, disp_upd}, 32'd1);
    press_str("C5");
    chk("mul0_b", {8'd0, disp_bcd}, 32'h000005);
    press_str("D");
    wait_done("mul0");
    chk("mul0_bcd", {8'd0, disp_bcd}, 32'h000000);
    press_str("7");
    chk("new_a7", {8'd0, disp_bcd}, 32'h000007);

    // Back-to-back strobes, digit limit, backspace floor
    press_str("E");
    @(negedge sys_clk);
    value_en = 1'b1; key_value = 4'd1;
    @(negedge sys_clk); key_value = 4'd2;
    @(negedge sys_clk); key_value = 4'd3;
    @(negedge sys_clk); key_value = 4'd4;
    @(negedge sys_clk); value_en = 1'b0;
    @(negedge sys_clk);
    chk("burst_1234", {8'd0, disp_bcd}, 32'h000123);
    press_str("F");
    chk("bsp_12", {8'd0, disp_bcd}, 32'h000012);
    press_str("FFF");
    chk("bsp_0", {8'd0, disp_bcd}, 32'h000000);
    press_str("5");
    chk("bsp_floor", {8'd0, disp_bcd}, 32'h000005);

    // 5 - 3 = 2 and bare A = 42
    press_str("E5B3D");
    wait_done("subpos");
    chk("subpos_bcd", {8'd0, disp_bcd}, 32'h000002);
    chk("subpos_neg", {31'd0, disp_neg}, 32'd0);
    press_str("E42D");
    wait_done("equ_a");
    chk("equ_a_bcd", {8'd0, disp_bcd}, 32'h000042);

    // Clear during conversion
    press_str("E5A5D");
    repeat (8) @(negedge sys_clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    press_str("E");
    chk("abort_upd", {31'd0, disp_upd}, 32'd1);
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (calc_done) saw_done = 1'b1;
      @(negedge sys_clk);
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    chk("abort_bcd", {8'd0, disp_bcd}, 32'h0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    press_str("3");
    chk("abort_in_sa", {8'd0, disp_bcd}, 32'h000003);

    // Asynchronous reset mid-entry
    press_str("E45");
    chk("pre_rst", {8'd0, disp_bcd}, 32'h000045);
    @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_bcd", {8'd0, disp_bcd}, 32'h0);
    chk("arst_upd", {31'd0, disp_upd}, 32'd0);
    chk("arst_neg", {31'd0, disp_neg}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    press_str("6");
    chk("post_rst", {8'd0, disp_bcd}, 32'h000006);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
